// File: rtl/prewish_load_sched.sv
// prewish_load_sched: arbitrates manual (debounced button + DIP) and timed
// (fixed 8-entry table) mask loads into the mentor, then holds off before
// the next load so the blinky can restart its pattern cleanly.
// Ports:
//   CLK_I      system clock
//   RST_I      asynchronous active-low reset
//   i_btn      raw load button, active-low, asynchronous
//   i_dip      8-bit DIP mask, sampled when a manual load is issued
//   i_auto_en  auto-cycling enable, asynchronous
//   STB_O      one-cycle load strobe to the mentor
//   DAT_O      mask to the mentor, held until the next load
//   o_busy     high while in STROBE or HOLD
//   o_src      source of the last load (1 = manual, 0 = auto)
module prewish_load_sched #(
    parameter int unsigned DEBOUNCE_BITS  = 16,
    parameter int unsigned AUTO_BITS      = 25,
    parameter int unsigned HOLDOFF_CYCLES = 64
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       i_btn,
    input  logic [7:0] i_dip,
    input  logic       i_auto_en,
    output logic       STB_O,
    output logic [7:0] DAT_O,
    output logic       o_busy,
    output logic       o_src
);

    localparam int unsigned HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STROBE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    logic                     r_btn_s1, r_btn_s2;
    logic                     r_auto_s1, r_auto_s2;
    logic                     r_db_state;
    logic [DEBOUNCE_BITS-1:0] r_db_cnt;
    logic [AUTO_BITS-1:0]     r_acnt;
    logic                     r_man_pend, r_auto_pend;
    logic [1:0]               r_state;
    logic [HOLD_W-1:0]        r_hold_cnt;
    logic [2:0]               r_idx;
    logic                     r_stb, r_busy, r_src;
    logic [7:0]               r_dat;

    logic                     w_btn_sync, w_auto_sync;
    logic                     w_db_flip, w_press, w_tick;
    logic [7:0]               w_tbl_val;
    logic [1:0]               w_state_nxt;
    logic [HOLD_W-1:0]        w_hold_nxt;
    logic                     w_man_nxt, w_auto_nxt, w_acnt_clr;
    logic [2:0]               w_idx_nxt;
    logic [7:0]               w_dat_nxt;
    logic                     w_src_nxt;

    assign w_btn_sync  = r_btn_s2;
    assign w_auto_sync = r_auto_s2;

    // Two-flop synchronizers; button resets to released (1), enable to off.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_btn_s1  <= 1'b1;
            r_btn_s2  <= 1'b1;
            r_auto_s1 <= 1'b0;
            r_auto_s2 <= 1'b0;
        end else begin
            r_btn_s1  <= i_btn;
            r_btn_s2  <= r_btn_s1;
            r_auto_s1 <= i_auto_en;
            r_auto_s2 <= r_auto_s1;
        end
    end

    // Debounce: state flips after 2^DEBOUNCE_BITS consecutive differing cycles.
    assign w_db_flip = (w_btn_sync != r_db_state) && (r_db_cnt == '1);
    assign w_press   = w_db_flip && r_db_state;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_db_state <= 1'b1;
            r_db_cnt   <= '0;
        end else if (w_btn_sync == r_db_state) begin
            r_db_cnt   <= '0;
        end else if (w_db_flip) begin
            r_db_state <= w_btn_sync;
            r_db_cnt   <= '0;
        end else begin
            r_db_cnt   <= r_db_cnt + DEBOUNCE_BITS'(1);
        end
    end

    // Auto timer; restarted by a manual load so the next auto load keeps a full period.
    assign w_tick = w_auto_sync && (r_acnt == '1);

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_acnt <= '0;
        end else if (!w_auto_sync || w_acnt_clr) begin
            r_acnt <= '0;
        end else begin
            r_acnt <= r_acnt + AUTO_BITS'(1);
        end
    end

    // Fixed auto mask table.
    always_comb begin
        w_tbl_val = 8'h80;
        case (r_idx)
            3'd0:    w_tbl_val = 8'h80;
            3'd1:    w_tbl_val = 8'hA0;
            3'd2:    w_tbl_val = 8'hA8;
            3'd3:    w_tbl_val = 8'hFF;
            3'd4:    w_tbl_val = 8'hD4;
            3'd5:    w_tbl_val = 8'hD5;
            3'd6:    w_tbl_val = 8'hCC;
            default: w_tbl_val = 8'hE0;
        endcase
    end

    // Next-state and load selection; new events coalesce into the pending flags.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_man_nxt   = r_man_pend | w_press;
        w_auto_nxt  = (r_auto_pend | w_tick) & w_auto_sync;
        w_acnt_clr  = 1'b0;
        w_idx_nxt   = r_idx;
        w_dat_nxt   = r_dat;
        w_src_nxt   = r_src;
        case (r_state)
            ST_IDLE: begin
                if (r_man_pend) begin
                    w_dat_nxt   = i_dip;
                    w_src_nxt   = 1'b1;
                    w_man_nxt   = w_press;
                    w_auto_nxt  = 1'b0;
                    w_acnt_clr  = 1'b1;
                    w_state_nxt = ST_STROBE;
                end else if (r_auto_pend) begin
                    w_dat_nxt   = w_tbl_val;
                    w_src_nxt   = 1'b0;
                    w_idx_nxt   = r_idx + 3'd1;
                    w_auto_nxt  = w_tick & w_auto_sync;
                    w_state_nxt = ST_STROBE;
                end
            end
            ST_STROBE: begin
                w_hold_nxt  = '0;
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (r_hold_cnt == HOLD_W'(HOLDOFF_CYCLES - 1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, flags and registered outputs.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_state     <= ST_IDLE;
            r_hold_cnt  <= '0;
            r_man_pend  <= 1'b0;
            r_auto_pend <= 1'b0;
            r_idx       <= 3'd0;
            r_dat       <= 8'h00;
            r_src       <= 1'b0;
            r_stb       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_man_pend  <= w_man_nxt;
            r_auto_pend <= w_auto_nxt;
            r_idx       <= w_idx_nxt;
            r_dat       <= w_dat_nxt;
            r_src       <= w_src_nxt;
            r_stb       <= (w_state_nxt == ST_STROBE);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign STB_O  = r_stb;
    assign DAT_O  = r_dat;
    assign o_busy = r_busy;
    assign o_src  = r_src;

endmodule

// File: tb/tb_prewish_load_sched.sv
// Directed bench for prewish_load_sched with short debounce/auto/hold-off
// parameters; inputs driven and outputs sampled on the falling clock edge.
module tb_prewish_load_sched;

    logic       clk;
    logic       rst_n;
    logic       btn;
    logic [7:0] dip;
    logic       auto_en;
    logic       stb;
    logic [7:0] dat;
    logic       busy;
    logic       src;

    int n_cmp = 0;
    int n_err = 0;

    prewish_load_sched #(
        .DEBOUNCE_BITS (3),
        .AUTO_BITS     (5),
        .HOLDOFF_CYCLES(4)
    ) u_dut (
        .CLK_I    (clk),
        .RST_I    (rst_n),
        .i_btn    (btn),
        .i_dip    (dip),
        .i_auto_en(auto_en),
        .STB_O    (stb),
        .DAT_O    (dat),
        .o_busy   (busy),
        .o_src    (src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Waits up to budget falling edges for STB_O; cyc = edges waited.
    task automatic wait_stb(input int budget, output int cyc, output bit found);
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (stb) found = 1'b1;
        end
    endtask

    task automatic count_stb(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (stb) cnt++;
        end
    endtask

    logic [7:0] tbl [10];
    int  cyc;
    int  cnt;
    int  acc;
    bit  found;

    initial begin
        tbl[0] = 8'h80; tbl[1] = 8'hA0; tbl[2] = 8'hA8; tbl[3] = 8'hFF; tbl[4] = 8'hD4;
        tbl[5] = 8'hD5; tbl[6] = 8'hCC; tbl[7] = 8'hE0; tbl[8] = 8'h80; tbl[9] = 8'hA0;

        rst_n   = 1'b0;
        btn     = 1'b1;
        dip     = 8'h00;
        auto_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stb", 32'(stb), 32'd0);
        check("rst_dat", 32'(dat), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_src", 32'(src), 32'd0);
        rst_n = 1'b1;

        // 1: idle, nothing happens
        count_stb(40, cnt);
        check("t1_no_stb", 32'(cnt), 32'd0);
        check("t1_dat", 32'(dat), 32'h00);
        check("t1_busy", 32'(busy), 32'd0);

        // 2: clean press, single strobe with the DIP value
        dip = 8'h5A;
        btn = 1'b0;
        wait_stb(30, cyc, found);
        check("t2_stb_seen", 32'(found), 32'd1);
        check("t2_latency", 32'(cyc >= 11 && cyc <= 13), 32'd1);
        check("t2_dat", 32'(dat), 32'h5A);
        check("t2_src", 32'(src), 32'd1);
        check("t2_busy", 32'(busy), 32'd1);
        count_stb(9, cnt);
        check("t2_single_pulse", 32'(cnt), 32'd0);
        btn = 1'b1;
        count_stb(30, cnt);
        check("t2_release_quiet", 32'(cnt), 32'd0);
        check("t2_dat_held", 32'(dat), 32'h5A);
        check("t2_idle", 32'(busy), 32'd0);

        // 3: bounce every 3 cycles, then hold
        dip = 8'h77;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            btn = ~btn;
            count_stb(3, cnt);
            acc += cnt;
        end
        check("t3_bounce_quiet", 32'(acc), 32'd0);
        btn = 1'b0;
        wait_stb(30, cyc, found);
        check("t3_stb_seen", 32'(found), 32'd1);
        check("t3_latency", 32'(cyc >= 11 && cyc <= 13), 32'd1);
        check("t3_dat", 32'(dat), 32'h77);
        count_stb(15, cnt);
        check("t3_one_strobe", 32'(cnt), 32'd0);
        btn = 1'b1;
        count_stb(20, cnt);
        check("t3_release_quiet", 32'(cnt), 32'd0);

        // 4: auto cycling through the table
        auto_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_stb(40, cyc, found);
            check($sformatf("t4_seen_%0d", k), 32'(found), 32'd1);
            if (k > 0) check($sformatf("t4_period_%0d", k), 32'(cyc), 32'd32);
            check($sformatf("t4_dat_%0d", k), 32'(dat), 32'(tbl[k]));
            check($sformatf("t4_src_%0d", k), 32'(src), 32'd0);
        end

        // 5: press event lands on the same edge as the next auto tick
        repeat (21) @(negedge clk);
        dip = 8'h3C;
        btn = 1'b0;
        wait_stb(20, cyc, found);
        check("t5_stb_seen", 32'(found), 32'd1);
        check("t5_latency", 32'(cyc >= 11 && cyc <= 13), 32'd1);
        check("t5_dat", 32'(dat), 32'h3C);
        check("t5_src", 32'(src), 32'd1);
        btn = 1'b1;
        wait_stb(40, cyc, found);
        check("t5_auto_seen", 32'(found), 32'd1);
        check("t5_auto_gap", 32'(cyc >= 31 && cyc <= 34), 32'd1);
        check("t5_auto_dat", 32'(dat), 32'hA8);
        check("t5_auto_src", 32'(src), 32'd0);

        // 6: reset during the strobe cycle
        wait_stb(40, cyc, found);
        check("t6_stb_seen", 32'(found), 32'd1);
        check("t6_dat_pre", 32'(dat), 32'hFF);
        rst_n = 1'b0;
        #1;
        check("t6_stb_drop", 32'(stb), 32'd0);
        check("t6_dat_rst", 32'(dat), 32'h00);
        check("t6_busy_rst", 32'(busy), 32'd0);
        check("t6_src_rst", 32'(src), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_stb(50, cyc, found);
        check("t6_auto_seen", 32'(found), 32'd1);
        check("t6_auto_dat", 32'(dat), 32'h80);
        check("t6_auto_src", 32'(src), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prewish_load_sched.md
Name: prewish_load_sched

Overview:
- Schedules mask loads into the prewish mentor/blinky datapath. Two requesters share it:
  - Manual: a debounced load button that captures the 8-bit DIP switch value.
  - Auto: a timer that steps through a fixed 8-entry mask table.
- Produces a one-cycle strobe with 8-bit data toward the mentor's STB_I/DAT_I.
- Manual requests have priority over auto requests.
- Enforces a hold-off between loads so the blinky can restart its pattern cleanly.

Parameters:
- DEBOUNCE_BITS, 16: button must hold a new level for 2^DEBOUNCE_BITS consecutive cycles before the debounced state changes.
- AUTO_BITS, 25: auto-load period is 2^AUTO_BITS cycles.
- HOLDOFF_CYCLES, 64: cycles spent in HOLD after each strobe; must be ≥ 1.

Ports:
- CLK_I  input  1  system clock
- RST_I  input  1  reset, asynchronous, active-low
- i_btn  input  1  raw load button, active-low (0 = pressed), asynchronous to CLK_I
- i_dip  input  8  DIP switch mask, quasi-static, sampled on load
- i_auto_en  input  1  enables auto cycling, asynchronous
- STB_O  output  1  load strobe to mentor, one-cycle pulse
- DAT_O  output  8  mask to mentor, valid while STB_O=1 and held until the next load
- o_busy  output  1  high in STROBE and HOLD
- o_src  output  1  source of the last load: 1 = manual, 0 = auto

Behaviour:
- Reset (RST_I=0, takes effect immediately):
  - STB_O=0, DAT_O=8'h00, o_busy=0, o_src=0.
  - State=IDLE, table index=0, pending flags=0, all counters=0.
  - Debounced button state=released; synchronizer flops=released/disabled.
- Synchronizers: i_btn and i_auto_en each pass through 2 flops before use.
- Debounce:
  - Counter resets to 0 whenever the synchronized button equals the debounced state.
  - Otherwise it increments each cycle; on reaching all-ones, the debounced state flips and the counter clears.
  - A press event is a released→pressed transition of the debounced state. Release events are ignored.
  - Holding the button yields exactly one event.
- Auto timer:
  - AUTO_BITS counter increments each cycle while synchronized auto_en=1.
  - Clears to 0 while auto_en=0.
  - Auto tick occurs when the counter wraps from all-ones to 0.
- Pending flags (one deep each):
  - man_pend is set on a press event; auto_pend is set on an auto tick.
  - Events arriving while a flag is already set coalesce into it.
  - Events arriving in STROBE or HOLD are retained.
  - Clearing auto_en also clears auto_pend.
- FSM:
  - IDLE:
    - If man_pend: DAT_O←i_dip, o_src←1, clear man_pend, clear auto_pend, clear auto counter, go STROBE.
    - Else if auto_pend: DAT_O←table[idx], o_src←0, idx←idx+1 (3-bit, wraps 7→0), clear auto_pend, go STROBE.
    - Else stay.
  - STROBE: STB_O=1 for exactly this one cycle, then go HOLD with the hold-off counter=0.
  - HOLD: count to HOLDOFF_CYCLES-1, then go IDLE.
- Outputs:
  - STB_O is registered and high only in STROBE.
  - DAT_O changes only on the IDLE→STROBE edge.
- Latency: a flag set on edge N while in IDLE causes IDLE→STROBE on edge N+1, and STB_O is high during cycle N+1..N+2. Minimum spacing between strobes is HOLDOFF_CYCLES+2 cycles.
- Simultaneous events: if a press event and an auto tick arrive on the same cycle, manual is served and the auto tick is dropped (auto_pend cleared).
- Auto table by index 0–7: 80, A0, A8, FF, D4, D5, CC, E0 (hex).
- Mid-operation reset: STB_O drops asynchronously and pending requests are lost. A load is never half-issued, because DAT_O and STB_O are both reset.

Test Plan (DEBOUNCE_BITS=3, AUTO_BITS=5, HOLDOFF_CYCLES=4):
1. Reset then idle 40 cycles with auto_en=0, button released → STB_O never high; DAT_O=00; o_busy=0.
2. i_dip=5A; press button cleanly for 20 cycles → exactly one STB_O pulse of 1 cycle, 2+8+2 cycles (±1) after press; DAT_O=5A; o_src=1; release produces no strobe.
3. Button bounces (toggle every 3 cycles for 30 cycles), then is held → exactly one strobe, issued only after 8 stable cycles.
4. auto_en=1 for 10 periods → strobes every 32 cycles with DAT_O=80, A0, A8, FF, D4, D5, CC, E0, 80, A0; o_src=0.
5. Press event coincident with an auto tick (i_dip=3C) → single strobe with DAT_O=3C, o_src=1; next auto strobe 32 cycles later uses the unadvanced table entry.
6. Assert RST_I=0 during the STROBE cycle → STB_O drops immediately; after release, outputs are 00/0 and the next auto load uses DAT_O=80.
